cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the CPU datapath. Steps each instruction through fetch, decode, execute, memory and writeback using the 6-bit major opcode, and drives PC advance, instruction-register load, memory requests and register-file write strobes. The per-instruction field decoder supplies the datapath fields; this block supplies *when* each strobe fires. Sits between the instruction register/decoder and the PC, register file and shared instruction/data memory port.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles a memory request may wait for mem_ready (used only with MEM_TIMEOUT_EN).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
opcode  in  6  IR[31:26]; valid from DECODE onward.
branch_taken  in  1  ALU compare result; sampled in EXEC for opcodes 30/31.
mem_ready  in  1  memory completion; ignored when mem_req=0.
resume  in  1  leave HALT (level, sampled each cycle).
state  out  3  current FSM state (debug).
ir_load  out  1  load instruction register.
mem_req  out  1  memory request, held until mem_ready.
mem_addr_sel  out  1  0 = address from PC (fetch), 1 = address from ALU (data).
mem_we  out  1  1 = write.
mem_byte  out  1  1 = byte access, 0 = word.
reg_write_word  out  1  register-file word write strobe.
reg_write_byte  out  1  register-file byte write strobe.
pc_enable  out  1  one-cycle PC update strobe.
jump_sel  out  2  PC source (0 = PC+4, 1 = PC+offset, 2 = register, 3 = {PC[31:18], addr, 00}); valid only when pc_enable=1.
halted  out  1  FSM is in HALT.
illegal  out  1  sticky; an opcode of 32..63 was decoded.
retired_count  out  32  number of retired instructions.
bus_error  out  1  sticky memory timeout (only with MEM_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore, except ir_load = (state==FETCH) & mem_ready.
- Reset (asynchronous): state=FETCH, illegal=0, bus_error=0, retired_count=0; all strobes 0. Reset during a pending request drops mem_req immediately; the memory side tolerates abandoned requests.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0, mem_byte=0. Waits for mem_ready; on mem_ready, ir_load=1 and the FSM moves to DECODE.
- DECODE (1 cycle), by opcode:
  - 0 → HALT.
  - 32..63 → set illegal, → HALT.
  - Otherwise → EXEC.
- EXEC (1 cycle):
  - 1..23 (ALU) → WB.
  - 24..27 (load/store) → MEM.
  - 28..31 (jump/branch) → pc_enable=1, jump_sel as follows, then → FETCH:
    - 28 → 3.
    - 29 → 2.
    - 30/31 → 1 if branch_taken, else 0.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=opcode[0], mem_byte=opcode[1]. Waits for mem_ready.
  - Stores (25, 27): on ready, pc_enable=1, jump_sel=0, → FETCH.
  - Loads (24, 26): on ready → WB.
- WB (1 cycle): pc_enable=1, jump_sel=0, → FETCH.
  - reg_write_byte=1 for opcode 26.
  - reg_write_word=1 for opcodes 1..24.
- Latency excluding memory waits: ALU 4 cycles, load 5, store 4, jump 3.
- retired_count increments on every pc_enable pulse except the resume pulse; wraps at 2^32−1 → 0.
- HALT:
  - halted=1; PC is not advanced on entry.
  - If resume=1 and illegal=0 and bus_error=0: one cycle with pc_enable=1, jump_sel=0 (skips the halt word), then → FETCH.
  - With illegal or bus_error set, resume is ignored; only reset exits.
- mem_ready while mem_req=0 has no effect.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: an 8..16-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0. When it reaches TIMEOUT_CYCLES, set bus_error, drop mem_req and go to HALT. mem_ready arriving in the same cycle as the limit wins (normal completion).
- Undefined: no counter; waits indefinitely; bus_error tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds: state enum, opcode constants (OP_HALT=0, OP_LW=24, OP_SW=25, OP_LB=26, OP_SB=27, OP_JABS=28, OP_JREG=29), jump_sel encodings (JS_NEXT, JS_REL, JS_REG, JS_ABS), and the opcode-class enum (CLS_HALT, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_ILLEGAL).
- One combinational sub-module, cpu_op_class: maps opcode to class; the FSM stays in cpu_sequencer.

Test Plan:
- Opcode 5, mem_ready=1 on first fetch cycle → FETCH,DECODE,EXEC,WB; reg_write_word in cycle 4; pc_enable once, jump_sel=0; retired_count=1.
- Opcode 26, fetch ready after 3 wait cycles, data ready after 2 → mem_addr_sel=1, mem_byte=1, mem_we=0 in MEM; reg_write_byte=1 in WB; total 10 cycles.
- Opcode 30 with branch_taken=1, then again with 0 → pc_enable in EXEC with jump_sel=1, then 0; opcode 29 → jump_sel=2.
- Opcode 0, then resume=1 → halted=1, no pc_enable on entry; one pc_enable (jump_sel=0) on resume, retired_count unchanged, FETCH next.
- Opcode 40 → illegal=1, HALT; resume=1 ignored; rst=1 mid-cycle clears illegal and drops mem_req asynchronously.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 during MEM → bus_error=1 and HALT after 4 wait cycles; mem_ready in cycle 4 → normal completion instead.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the CPU sequencer slice.
// Holds the FSM state enum, major-opcode constants, jump_sel encodings and opcode classes.
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {CLS_HALT, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_ILLEGAL} op_class_t;
  localparam logic [5:0] OP_HALT = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd24;
  localparam logic [5:0] OP_SW   = 6'd25;
  localparam logic [5:0] OP_LB   = 6'd26;
  localparam logic [5:0] OP_SB   = 6'd27;
  localparam logic [5:0] OP_JABS = 6'd28;
  localparam logic [5:0] OP_JREG = 6'd29;
  localparam logic [1:0] JS_NEXT = 2'd0;
  localparam logic [1:0] JS_REL  = 2'd1;
  localparam logic [1:0] JS_REG  = 2'd2;
  localparam logic [1:0] JS_ABS  = 2'd3;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the datapath and the sequencer.
// master = datapath side (drives opcode/branch_taken/mem_ready/resume),
// slave  = sequencer side (drives state, strobes, status and retired_count).
interface cpu_sequencer_if;
  logic [5:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        resume;
  logic [2:0]  state;
  logic        ir_load;
  logic        mem_req;
  logic        mem_addr_sel;
  logic        mem_we;
  logic        mem_byte;
  logic        reg_write_word;
  logic        reg_write_byte;
  logic        pc_enable;
  logic [1:0]  jump_sel;
  logic        halted;
  logic        illegal;
  logic [31:0] retired_count;
  logic        bus_error;
  modport master (
    output opcode, branch_taken, mem_ready, resume,
    input  state, ir_load, mem_req, mem_addr_sel, mem_we, mem_byte, reg_write_word,
           reg_write_byte, pc_enable, jump_sel, halted, illegal, retired_count, bus_error
  );
  modport slave (
    input  opcode, branch_taken, mem_ready, resume,
    output state, ir_load, mem_req, mem_addr_sel, mem_we, mem_byte, reg_write_word,
           reg_write_byte, pc_enable, jump_sel, halted, illegal, retired_count, bus_error
  );
endinterface

// File: rtl/cpu_sequencer_op_class.sv
// cpu_op_class: maps a 6-bit major opcode to its execution class.
// Ports: opcode (in, 6) -> op_class (out, op_class_t).
module cpu_op_class
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);
  always_comb
    op_class = opcode[5]                            ? CLS_ILLEGAL :
               opcode == OP_HALT                    ? CLS_HALT    :
               opcode < OP_LW                       ? CLS_ALU     :
               (opcode == OP_LW || opcode == OP_LB) ? CLS_LOAD    :
               opcode < OP_JABS                     ? CLS_STORE   : CLS_JUMP;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT control FSM for the CPU datapath.
// Ports: clk, rst (async, active-high); bus (cpu_sequencer_if.slave) carries opcode,
// branch_taken, mem_ready, resume in and state, strobes, halted/illegal/bus_error and retired_count out.
// Optional: define MEM_TIMEOUT_EN to abort memory waits after TIMEOUT_CYCLES with a sticky bus_error.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  cpu_sequencer_if.slave bus
);
  state_t      st;
  op_class_t   cls;
  logic        ill;
  logic        berr;
  logic [31:0] retired;
  logic        mem_wait;
  logic        timeout;
  logic        resume_go;
  logic        pc_en;
  cpu_op_class u_op_class (.opcode(bus.opcode), .op_class(cls));
  assign mem_wait = st == S_FETCH || st == S_MEM;
`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  // Only waits stay in FETCH/MEM, so zeroing whenever the wait ends also clears it on entry.
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else wait_cnt <= (mem_wait && !bus.mem_ready) ? wait_cnt + 16'd1 : '0;
  // A ready arriving on the limit cycle completes normally because timeout requires !mem_ready.
  assign timeout = mem_wait && !bus.mem_ready && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES == 0;
  assign timeout = 1'b0;
`endif
  assign resume_go = st == S_HALT && bus.resume && !ill && !berr;
  assign pc_en = (st == S_EXEC && cls == CLS_JUMP) || (st == S_MEM && cls == CLS_STORE && bus.mem_ready) ||
                 st == S_WB || resume_go;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= S_FETCH;
      ill     <= 1'b0;
      berr    <= 1'b0;
      retired <= '0;
    end else begin
      if (pc_en && !resume_go) retired <= retired + 32'd1;
      if (timeout) berr <= 1'b1;
      if (st == S_DECODE && cls == CLS_ILLEGAL) ill <= 1'b1;
      case (st)
        S_FETCH:  st <= timeout ? S_HALT : bus.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: st <= (cls == CLS_HALT || cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
        S_EXEC:   st <= cls == CLS_JUMP ? S_FETCH : (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEM : S_WB;
        S_MEM:    st <= timeout ? S_HALT : !bus.mem_ready ? S_MEM : cls == CLS_STORE ? S_FETCH : S_WB;
        S_WB:     st <= S_FETCH;
        S_HALT:   st <= resume_go ? S_FETCH : S_HALT;
        default:  st <= S_FETCH;
      endcase
    end
  assign bus.state          = st;
  // Reset drops the request at once, even though reset parks the FSM in FETCH.
  assign bus.mem_req        = mem_wait && !rst;
  assign bus.ir_load        = st == S_FETCH && bus.mem_ready && !rst;
  assign bus.mem_addr_sel   = st == S_MEM;
  assign bus.mem_we         = st == S_MEM && bus.opcode[0];
  assign bus.mem_byte       = st == S_MEM && bus.opcode[1];
  assign bus.reg_write_word = st == S_WB && (cls == CLS_ALU || bus.opcode == OP_LW);
  assign bus.reg_write_byte = st == S_WB && bus.opcode == OP_LB;
  assign bus.pc_enable      = pc_en;
  assign bus.jump_sel       = !(st == S_EXEC && cls == CLS_JUMP) ? JS_NEXT :
                              bus.opcode == OP_JABS ? JS_ABS :
                              bus.opcode == OP_JREG ? JS_REG :
                              bus.branch_taken ? JS_REL : JS_NEXT;
  assign bus.halted         = st == S_HALT;
  assign bus.illegal        = ill;
  assign bus.bus_error      = berr;
  assign bus.retired_count  = retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream checked cycle by cycle against a per-class model.
module tb_cpu_sequencer;
  import cpu_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int unsigned exp_ret = 0;
  bit exp_ill = 1'b0;
  cpu_sequencer_if bus ();
  cpu_sequencer #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input int op, input int fw);
    for (int i = 0; i <= fw; i++) begin
      bus.opcode = 6'($urandom);
      bus.mem_ready = (i == fw);
      bus.resume = 1'b0;
      #1;
      chk("f_state", 32'(bus.state), 32'(S_FETCH));
      chk("f_req", 32'(bus.mem_req), 1);
      chk("f_sel", 32'(bus.mem_addr_sel), 0);
      chk("f_we", 32'(bus.mem_we), 0);
      chk("f_byte", 32'(bus.mem_byte), 0);
      chk("f_irld", 32'(bus.ir_load), 32'(i == fw));
      chk("f_pc", 32'(bus.pc_enable), 0);
      step();
    end
    bus.opcode = 6'(op);
    bus.mem_ready = 1'($urandom);
    #1;
    chk("d_state", 32'(bus.state), 32'(S_DECODE));
    chk("d_req", 32'(bus.mem_req), 0);
    chk("d_pc", 32'(bus.pc_enable), 0);
    step();
  endtask
  task automatic run_instr(input int op, input int fw, input int mw, input bit bt);
    bit jmp = op >= 28 && op <= 31;
    bit ld = op == 24 || op == 26;
    bit stw = op == 25 || op == 27;
    bit alu = op >= 1 && op <= 23;
    fetch_decode(op, fw);
    if (op == 0) begin
      for (int k = 0; k < 2; k++) begin
        bus.mem_ready = 1'($urandom);
        #1;
        chk("h_state", 32'(bus.state), 32'(S_HALT));
        chk("h_halted", 32'(bus.halted), 1);
        chk("h_pc", 32'(bus.pc_enable), 0);
        chk("h_req", 32'(bus.mem_req), 0);
        step();
      end
      bus.resume = 1'b1;
      #1;
      chk("r_pc", 32'(bus.pc_enable), 1);
      chk("r_js", 32'(bus.jump_sel), 0);
      step();
      bus.resume = 1'b0;
      chk("r_state", 32'(bus.state), 32'(S_FETCH));
    end else begin
      bus.branch_taken = bt;
      bus.mem_ready = 1'($urandom);
      #1;
      chk("e_state", 32'(bus.state), 32'(S_EXEC));
      chk("e_pc", 32'(bus.pc_enable), 32'(jmp));
      if (jmp) chk("e_js", 32'(bus.jump_sel), op == 28 ? 3 : op == 29 ? 2 : bt ? 1 : 0);
      step();
      if (jmp) exp_ret++;
      if (ld || stw) begin
        for (int i = 0; i <= mw; i++) begin
          bus.mem_ready = (i == mw);
          #1;
          chk("m_state", 32'(bus.state), 32'(S_MEM));
          chk("m_req", 32'(bus.mem_req), 1);
          chk("m_sel", 32'(bus.mem_addr_sel), 1);
          chk("m_we", 32'(bus.mem_we), 32'(stw));
          chk("m_byte", 32'(bus.mem_byte), 32'(op == 26 || op == 27));
          chk("m_pc", 32'(bus.pc_enable), 32'(stw && i == mw));
          if (stw && i == mw) chk("m_js", 32'(bus.jump_sel), 0);
          step();
        end
        if (stw) exp_ret++;
      end
      if (alu || ld) begin
        bus.mem_ready = 1'($urandom);
        #1;
        chk("w_state", 32'(bus.state), 32'(S_WB));
        chk("w_pc", 32'(bus.pc_enable), 1);
        chk("w_js", 32'(bus.jump_sel), 0);
        chk("w_rww", 32'(bus.reg_write_word), 32'(op <= 24));
        chk("w_rwb", 32'(bus.reg_write_byte), 32'(op == 26));
        chk("w_req", 32'(bus.mem_req), 0);
        step();
        exp_ret++;
      end
    end
    chk("retired", bus.retired_count, exp_ret);
    chk("illegal", 32'(bus.illegal), 32'(exp_ill));
    chk("berr", 32'(bus.bus_error), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b0;
    bus.resume = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 32'(S_FETCH));
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_ill", 32'(bus.illegal), 0);
    chk("rst_ret", bus.retired_count, 0);
    chk("rst_pc", 32'(bus.pc_enable), 0);
    step();
    rst = 1'b0;
    #1;
    chk("pend_req", 32'(bus.mem_req), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_drop_req", 32'(bus.mem_req), 0);
    step();
    rst = 1'b0;
    run_instr(5, 0, 0, 0);
    run_instr(26, 3, 2, 0);
    run_instr(30, 1, 0, 1);
    run_instr(30, 0, 0, 0);
    run_instr(29, 2, 0, 0);
    run_instr(28, 0, 0, 1);
    run_instr(0, 1, 0, 0);
    run_instr(25, 0, 3, 0);
    run_instr(27, 2, 1, 0);
    run_instr(24, 1, 1, 1);
    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
`ifdef MEM_TIMEOUT_EN
    fetch_decode(24, 0);
    bus.branch_taken = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      chk("to_state", 32'(bus.state), 32'(S_MEM));
      step();
    end
    bus.resume = 1'b1;
    #1;
    chk("to_halt", 32'(bus.state), 32'(S_HALT));
    chk("to_berr", 32'(bus.bus_error), 1);
    chk("to_req", 32'(bus.mem_req), 0);
    chk("to_nores", 32'(bus.pc_enable), 0);
    rst = 1'b1;
    exp_ret = 0;
    step();
    rst = 1'b0;
    chk("to_clr", 32'(bus.bus_error), 0);
`endif
    fetch_decode(40, 1);
    exp_ill = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.resume = 1'b1;
      #1;
      chk("ill_flag", 32'(bus.illegal), 1);
      chk("ill_state", 32'(bus.state), 32'(S_HALT));
      chk("ill_nores", 32'(bus.pc_enable), 0);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    exp_ill = 1'b0;
    exp_ret = 0;
    chk("ill_clr", 32'(bus.illegal), 0);
    chk("ill_rst_state", 32'(bus.state), 32'(S_FETCH));
    chk("ill_rst_req", 32'(bus.mem_req), 0);
    chk("ill_rst_ret", bus.retired_count, 0);
    step();
    rst = 1'b0;
    run_instr(7, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
